// File: rtl/window_3x3_gen.sv
// window_3x3_gen: 3x3 sliding-window generator over a raster pixel stream.
// Two line buffers hold the previous two rows. A 3x3 register window shifts
// one column per accepted pixel. A window is emitted only when it lies
// entirely inside the current frame (row >= 2 and col >= 2).
// Optional feature macro: WINDOW_3X3_GEN_TLAST_EN adds m_tlast, which flags
// the last window of each frame.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A source holds valid and data stable until that edge. s_tready
// depends only on the output slot state and m_tready.
module window_3x3_gen #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_tvalid,
    input  logic [7:0]  s_tdata,
    output logic        s_tready,
    output logic        m_tvalid,
    output logic [71:0] m_tdata,
    input  logic        m_tready,
`ifdef WINDOW_3X3_GEN_TLAST_EN
    output logic        m_tlast,
`endif
    output logic        frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [7:0]    top_buf [IMG_W];
    logic [7:0]    mid_buf [IMG_W];
    logic [7:0]    win     [3][3];
    logic [7:0]    nxt     [3][3];
    logic [71:0]   win_flat;
    logic          accept;
    logic          last_col;
    logic          last_row;
    logic          emit;

    // A single output slot: space is available when the slot is empty or is draining this cycle.
    assign s_tready = !m_tvalid || m_tready;
    assign accept   = s_tvalid && s_tready;
    assign last_col = (col == CW'(IMG_W - 1));
    assign last_row = (row == RW'(IMG_H - 1));
    // Border pixels only prime the buffers, so stale data never reaches an emitted window.
    assign emit     = accept && (row >= RW'(2)) && (col >= CW'(2));

    // Next window: shift left by one column, then load the new right column from the buffers and the pixel.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            nxt[r][0] = win[r][1];
            nxt[r][1] = win[r][2];
            nxt[r][2] = 8'd0;
        end
        nxt[0][2] = top_buf[col];
        nxt[1][2] = mid_buf[col];
        nxt[2][2] = s_tdata;
    end

    // Flatten the next window into the output layout: element (r,c) goes to byte 3r+c.
    always_comb begin
        win_flat = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win_flat[8*(3*r+c) +: 8] = nxt[r][c];
            end
        end
    end

    // Line buffers and window are data-path storage without reset; output gating keeps them safe.
    always_ff @(posedge clk) begin
        if (accept) begin
            top_buf[col] <= mid_buf[col];
            mid_buf[col] <= s_tdata;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= nxt[r][c];
                end
            end
        end
    end

    // Raster position of the next pixel to arrive; wraps at end of row and end of frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Output slot: load on emit, empty after a handshake, and pulse frame_done on the final pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_tvalid   <= 1'b0;
            m_tdata    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && last_col && last_row;
            if (emit) begin
                m_tvalid <= 1'b1;
                m_tdata  <= win_flat;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end
        end
    end

`ifdef WINDOW_3X3_GEN_TLAST_EN
    // Last-window flag travels with m_tdata and is held during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_tlast <= 1'b0;
        end else if (emit) begin
            m_tlast <= last_col && last_row;
        end
    end
`endif

endmodule

// File: doc/window_3x3_gen.md
WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 28, pixels per row (legal range 3..1024).
REQ-002 SHALL have parameter IMG_H, default 28, rows per frame (legal range 3..1024).
REQ-003 SHALL have port clk, input, 1, the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port s_tvalid, input, 1, upstream byte-stream pixel valid (raster order, row-major).
REQ-006 SHALL have port s_tdata, input, 8, unsigned pixel byte.
REQ-007 SHALL have port s_tready, output, 1, pixel accepted when s_tvalid and s_tready are both high.
REQ-008 SHALL have port m_tvalid, output, 1, 3x3 window valid.
REQ-009 SHALL have port m_tdata, output, 72, window; element (r,c), r=0 top, c=0 left, at bits [8*(3r+c)+7 : 8*(3r+c)].
REQ-010 SHALL have port m_tready, input, 1, downstream accept.
REQ-011 SHALL have port frame_done, output, 1, one-cycle pulse on acceptance of the last pixel of a frame.

Function
REQ-012 SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1), advanced only on an accepted pixel; col wraps to 0 and increments row; at (IMG_H-1, IMG_W-1) both wrap to 0.
REQ-013 SHALL hold two line buffers of IMG_W bytes: top (row-2) and mid (row-1).
REQ-014 On accepted pixel p at col c: the window shifts one column left; new right column = {top[c], mid[c], p}; then top[c] <= mid[c], mid[c] <= p, all in the same cycle.
REQ-015 SHALL produce a window only for accepted pixels with row >= 2 and col >= 2; exactly (IMG_W-2)*(IMG_H-2) windows per frame, no padding.
REQ-016 SHALL register the output: m_tvalid/m_tdata update on the clock edge that accepts the completing pixel (latency 1 cycle).
REQ-017 SHALL assert s_tready = !m_tvalid || m_tready (single output slot, full throughput of one pixel per cycle with m_tready high).
REQ-018 While m_tvalid && !m_tready, m_tdata SHALL remain stable and no pixel SHALL be accepted.
REQ-019 SHALL clear m_tvalid after a handshake unless a new window is loaded in the same cycle.
REQ-020 Accepted pixels with row < 2 or col < 2 SHALL update line buffers and window but SHALL NOT set m_tvalid.
REQ-021 Consecutive frames SHALL stream back-to-back with no idle cycle; stale line-buffer data from the previous frame SHALL never appear in an emitted window.
REQ-022 frame_done SHALL pulse high for exactly one cycle after acceptance of pixel (IMG_H-1, IMG_W-1), independent of m_tready.

Reset
REQ-023 With rst high at a clock edge: col=0, row=0, m_tvalid=0, m_tdata=0, frame_done=0, m_tlast=0 (when present).
REQ-024 Line-buffer and window contents SHALL NOT be reset; correctness relies on REQ-015 gating.
REQ-025 Reset mid-frame SHALL discard the partial frame; the next accepted pixel is treated as (0,0).
REQ-026 s_tready SHALL be high in the first cycle after reset.

Configuration
REQ-027 Macro WINDOW_3X3_GEN_TLAST_EN: when defined, SHALL add output m_tlast (1 bit), high with the last window of a frame (pixel (IMG_H-1, IMG_W-1)), registered and held together with m_tdata.
REQ-028 When WINDOW_3X3_GEN_TLAST_EN is undefined, the m_tlast port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-029 IMG_W=4, IMG_H=4, pixels 0..15, m_tready=1 -> 4 windows; first = {0,1,2,4,5,6,8,9,10}, last = {5,6,7,9,10,11,13,14,15}; frame_done one pulse after pixel 15.
REQ-030 Same stimulus, m_tready low for 5 cycles when first window appears -> s_tready=0, m_tdata held at first window, no pixel lost, all 4 windows correct afterward.
REQ-031 Two 4x4 frames back-to-back (0..15 then 100..115) -> 8 windows; fifth = {100,101,102,104,105,106,108,109,110}; no window mixing frames.
REQ-032 rst asserted after 7 pixels, then full 4x4 frame 0..15 -> exactly 4 windows identical to REQ-029; m_tvalid=0 in the cycle after reset.
REQ-033 With WINDOW_3X3_GEN_TLAST_EN defined, 4x4 frame -> m_tlast=1 only on the fourth window; IMG_W=28, IMG_H=28 default frame -> 676 windows, m_tlast only on the 676th.
